// File: rtl/memory_controller_fsm.sv
`default_nettype none
// ============================================================================
// memory_controller_fsm
//   Button-driven stack controller: pushes switch values and runs pop-pop-push
//   ALU computes against an external stack memory.
//   Revision: 1.0
// ============================================================================
module memory_controller_fsm #(
   parameter int STACK_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] switches,
   input  logic [4:0]  btns,
   input  logic [31:0] aluOut,
   input  logic [31:0] memOut,
   output logic        push,
   output logic        pop,
   output logic [31:0] aluA,
   output logic [31:0] aluB,
   output logic [31:0] memIn
);

   localparam int CW = $clog2(STACK_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PUSH_SW  = 3'd1,
      S_POP_B    = 3'd2,
      S_WAIT_B   = 3'd3,
      S_POP_A    = 3'd4,
      S_WAIT_A   = 3'd5,
      S_PUSH_RES = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_btns;
   logic [1:0]    w_rise;
   logic [CW-1:0] r_count;
   logic [31:0]   r_alu_a;
   logic [31:0]   r_alu_b;
   logic [31:0]   r_mem_in;
   logic          w_full;
   logic          w_can_compute;
   logic          w_unused_btns;

   assign w_unused_btns = ^btns[4:2];
   assign w_rise        = btns[1:0] & ~r_btns;
   assign w_full        = (r_count == CW'(STACK_DEPTH));
   assign w_can_compute = (r_count >= CW'(2));

   always_comb begin
      w_next = r_state;
      push   = 1'b0;
      pop    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A switch press wins the cycle even when it is refused for a full stack.
            if (w_rise[0]) begin
               if (!w_full) w_next = S_PUSH_SW;
            end else if (w_rise[1] && w_can_compute) begin
               w_next = S_POP_B;
            end
         end
         S_PUSH_SW: begin
            push   = 1'b1;
            w_next = S_IDLE;
         end
         S_POP_B: begin
            pop    = 1'b1;
            w_next = S_WAIT_B;
         end
         S_WAIT_B: w_next = S_POP_A;
         S_POP_A: begin
            pop    = 1'b1;
            w_next = S_WAIT_A;
         end
         S_WAIT_A: w_next = S_PUSH_RES;
         S_PUSH_RES: begin
            push   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_btns   <= 2'b00;
         r_count  <= '0;
         r_alu_a  <= 32'h0;
         r_alu_b  <= 32'h0;
         r_mem_in <= 32'h0;
      end else begin
         r_state <= w_next;
         r_btns  <= btns[1:0];
         if (r_state == S_IDLE && w_next == S_PUSH_SW) r_mem_in <= {16'h0000, switches};
         if (r_state == S_WAIT_B) r_alu_b <= memOut;
         if (r_state == S_WAIT_A) r_alu_a <= memOut;
         if (r_state == S_PUSH_RES) r_mem_in <= aluOut;
         if (push)     r_count <= r_count + CW'(1);
         else if (pop) r_count <= r_count - CW'(1);
      end
   end

   // aluOut only reflects the new operands once aluA is loaded, so the result
   // is forwarded during PUSH_RES and captured for holding afterwards.
   assign memIn = (r_state == S_PUSH_RES) ? aluOut : r_mem_in;
   assign aluA  = r_alu_a;
   assign aluB  = r_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_memory_controller_fsm.sv
`default_nettype none
// ============================================================================
// tb_memory_controller_fsm
//   Directed and random stimulus against a transaction-level stack model.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_memory_controller_fsm;

   localparam int DEPTH = 256;
   localparam int MAXC  = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] switches;
   logic [4:0]  btns;
   logic [31:0] alu_out;
   logic [31:0] mem_out;
   logic        push;
   logic        pop;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] mem_in;

   always #5 clk = ~clk;

   assign alu_out = alu_a + alu_b;

   memory_controller_fsm #(.STACK_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .switches (switches),
      .btns     (btns),
      .aluOut   (alu_out),
      .memOut   (mem_out),
      .push     (push),
      .pop      (pop),
      .aluA     (alu_a),
      .aluB     (alu_b),
      .memIn    (mem_in)
   );

   int chk_cnt = 0;
   int err_cnt = 0;
   int cyc     = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // Stack memory environment: pop data appears the cycle after the strobe.
   logic [31:0] env_stk[$];
   always @(posedge clk) begin
      if (rst) begin
         env_stk.delete();
         mem_out <= 32'h0;
      end else begin
         if (pop) begin
            if (env_stk.size() > 0) mem_out <= env_stk.pop_back();
            else                    mem_out <= 32'hDEADBEEF;
         end
         if (push) env_stk.push_back(mem_in);
      end
   end

   // Expected strobes and register updates scheduled per cycle index.
   bit          e_push[MAXC];
   bit          e_pop[MAXC];
   bit          s_a_v[MAXC];
   bit          s_b_v[MAXC];
   bit          s_m_v[MAXC];
   logic [31:0] s_a[MAXC];
   logic [31:0] s_b[MAXC];
   logic [31:0] s_m[MAXC];
   logic [31:0] m_stk[$];
   int          m_count = 0;
   int          next_ok = 0;
   logic [1:0]  m_prev  = 2'b00;
   logic [1:0]  rise;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] m_a   = 32'h0;
   logic [31:0] m_b   = 32'h0;
   logic [31:0] m_mem = 32'h0;

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (cyc < MAXC - 8) begin
            if (rst) begin
               for (int i = cyc; i < MAXC; i++) begin
                  e_push[i] = 1'b0; e_pop[i] = 1'b0;
                  s_a_v[i] = 1'b0; s_b_v[i] = 1'b0; s_m_v[i] = 1'b0;
               end
               m_stk.delete();
               m_count = 0;
               m_prev  = 2'b00;
               next_ok = cyc + 1;
               s_a_v[cyc] = 1'b1; s_a[cyc] = 32'h0;
               s_b_v[cyc] = 1'b1; s_b[cyc] = 32'h0;
               s_m_v[cyc] = 1'b1; s_m[cyc] = 32'h0;
            end else begin
               rise   = btns[1:0] & ~m_prev;
               m_prev = btns[1:0];
               if (cyc >= next_ok) begin
                  if (rise[0]) begin
                     if (m_count < DEPTH) begin
                        e_push[cyc] = 1'b1;
                        s_m_v[cyc]  = 1'b1;
                        s_m[cyc]    = {16'h0000, switches};
                        m_stk.push_back({16'h0000, switches});
                        m_count++;
                        next_ok = cyc + 2;
                     end
                  end else if (rise[1] && m_count >= 2) begin
                     op_b = m_stk.pop_back();
                     op_a = m_stk.pop_back();
                     m_stk.push_back(op_a + op_b);
                     m_count--;
                     e_pop[cyc]      = 1'b1;
                     e_pop[cyc + 2]  = 1'b1;
                     e_push[cyc + 4] = 1'b1;
                     s_b_v[cyc + 2]  = 1'b1; s_b[cyc + 2] = op_b;
                     s_a_v[cyc + 4]  = 1'b1; s_a[cyc + 4] = op_a;
                     s_m_v[cyc + 4]  = 1'b1; s_m[cyc + 4] = op_a + op_b;
                     next_ok = cyc + 6;
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cyc > 0 && cyc < MAXC - 8) begin
            if (s_a_v[cyc]) m_a   = s_a[cyc];
            if (s_b_v[cyc]) m_b   = s_b[cyc];
            if (s_m_v[cyc]) m_mem = s_m[cyc];
            check_val("push",  {31'h0, push}, {31'h0, e_push[cyc]});
            check_val("pop",   {31'h0, pop},  {31'h0, e_pop[cyc]});
            check_val("aluA",  alu_a,  m_a);
            check_val("aluB",  alu_b,  m_b);
            if (push) check_val("memIn", mem_in, m_mem);
            else      check_val("memIn_hold", mem_in, m_mem);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input logic [4:0] b, input logic [15:0] sw, input int hold, input int gap);
      switches = sw;
      btns     = b;
      tick(hold);
      btns = 5'b0;
      tick(gap);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      btns = 5'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      // Button held through reset registers as a press afterwards.
      rst      = 1'b1;
      btns     = 5'b00001;
      switches = 16'h00AA;
      tick(3);
      rst = 1'b0;
      tick(3);
      btns = 5'b0;
      tick(2);

      do_reset();
      press(5'b00001, 16'h0005, 5, 3);

      do_reset();
      press(5'b00001, 16'h0003, 2, 2);
      press(5'b00001, 16'h0004, 2, 2);
      press(5'b00010, 16'h0000, 1, 8);

      do_reset();
      press(5'b00001, 16'h0009, 1, 2);
      press(5'b00010, 16'h0000, 2, 8);

      do_reset();
      for (int i = 1; i <= 100; i++) press(5'b00001, 16'(i), 3, 3);
      press(5'b00011, 16'h1234, 2, 8);

      // Reset while the compute sits in WAIT_B.
      do_reset();
      press(5'b00001, 16'h0011, 1, 2);
      press(5'b00001, 16'h0022, 1, 2);
      btns = 5'b00010;
      tick(2);
      rst  = 1'b1;
      btns = 5'b0;
      tick(1);
      rst = 1'b0;
      tick(3);

      // Fill to capacity, then one refused push and a compute.
      do_reset();
      for (int i = 0; i < DEPTH; i++) press(5'b00001, 16'(i * 3 + 1), 1, 1);
      press(5'b00001, 16'hFFFF, 1, 2);
      press(5'b00010, 16'h0000, 1, 8);
      press(5'b00001, 16'hBEEF, 1, 2);

      do_reset();
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 2) == 0) btns = 5'($urandom_range(0, 31));
         switches = 16'($urandom);
         rst = ($urandom_range(0, 149) == 0);
         tick(1);
      end
      rst  = 1'b0;
      btns = 5'b0;
      tick(8);

      if (cyc >= MAXC - 8) check_val("cycle_budget", 32'(cyc), 32'(MAXC - 8));
      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_controller_fsm.md
MEMORY_CONTROLLER_FSM -- requirements
Module: Memory_Controller

Interface
REQ-001 Parameter STACK_DEPTH, default 256: number of 32-bit entries in the external stack memory; used only for full/empty tracking.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 switches  input  16  operand value for switch pushes.
REQ-005 btns  input  5  buttons, held level-high by the user: [0] push switches, [1] compute; [4:2] are unused and SHALL be ignored.
REQ-006 aluOut  input  32  combinational ALU result computed externally from aluA and aluB.
REQ-007 memOut  input  32  stack top data; valid in the cycle after a pop pulse.
REQ-008 push  output  1  one-cycle push strobe to the stack memory.
REQ-009 pop  output  1  one-cycle pop strobe to the stack memory.
REQ-010 aluA  output  32  registered ALU operand A.
REQ-011 aluB  output  32  registered ALU operand B.
REQ-012 memIn  output  32  registered write data to the stack; valid whenever push=1.

Function
REQ-013 The block SHALL register btns every cycle and detect a press as a 0->1 rising edge per bit; holding a button SHALL produce exactly one operation.
REQ-014 A press SHALL be accepted only in state IDLE; presses while the FSM is busy SHALL be dropped, not queued.
REQ-015 If rising edges occur on btns[0] and btns[1] in the same cycle, btns[0] SHALL take priority and btns[1] SHALL be dropped.
REQ-016 The FSM states SHALL be IDLE, PUSH_SW, POP_B, WAIT_B, POP_A, WAIT_A and PUSH_RES; every non-IDLE state lasts exactly one cycle.
REQ-017 On an accepted btns[0] press, the block SHALL capture memIn={16'h0000,switches} and go to PUSH_SW.
REQ-018 PUSH_SW SHALL assert push=1 for one cycle, increment count, then return to IDLE.
REQ-019 An accepted btns[1] press SHALL go to POP_B.
REQ-020 POP_B SHALL assert pop=1; WAIT_B SHALL latch aluB<=memOut.
REQ-021 POP_A SHALL assert pop=1; WAIT_A SHALL latch aluA<=memOut.
REQ-022 At the end of WAIT_A, the block SHALL register memIn<=aluOut, using the combinational result of the updated aluA and aluB on the next cycle; the implementation SHALL ensure memIn equals aluOut for the new operands while push=1 in PUSH_RES.
REQ-023 PUSH_RES SHALL assert push=1 for one cycle, then return to IDLE.
REQ-024 A compute SHALL decrement count by 1 in total: two pops and one push.
REQ-025 The press-to-push latency SHALL be 1 cycle after acceptance for a switch push and 5 cycles for a compute.
REQ-026 An internal counter count, ranging 0..STACK_DEPTH, SHALL track stack occupancy.
REQ-027 A btns[0] press SHALL be ignored when count==STACK_DEPTH: no strobe is issued.
REQ-028 A btns[1] press SHALL be ignored when count<2: no strobe is issued and aluA and aluB are unchanged.
REQ-029 push and pop SHALL never be high in the same cycle.
REQ-030 push and pop SHALL be low in IDLE.
REQ-031 aluA, aluB and memIn SHALL hold their values between operations.

Reset
REQ-032 When rst=1 at a rising clk edge, the block SHALL go to IDLE, clear count to 0, drive push=0 and pop=0, and clear aluA, aluB and memIn to 0.
REQ-033 The registered btns history SHALL be cleared to 0 on reset, so a button held through reset registers as a press on the first cycle after reset.
REQ-034 Reset mid-operation SHALL abort the operation; any partially performed pops are not undone.

Verification
REQ-035 Scenario: switches=16'h0005, btns[0] 0->1 held 5 cycles -> exactly one push pulse with memIn=32'h00000005; count=1.
REQ-036 Scenario: push 3, push 4, then btns[1] press with an adder ALU and a stack model returning 4 then 3 -> aluB=4, aluA=3, one push pulse with memIn=32'h00000007; count=1.
REQ-037 Scenario: btns[1] pressed with count=1 -> no push or pop pulse; aluA and aluB unchanged.
REQ-038 Scenario: 100 successive switch pushes of the values 1..100, each press held 3 cycles with 3 idle cycles between presses -> 100 push pulses, each with memIn={16'h0,switches}.
REQ-039 Scenario: btns=5'b00011 rising together -> switch push only; no pop pulse.
REQ-040 Scenario: rst asserted during WAIT_B -> next cycle the block is IDLE with push=pop=0 and aluA=aluB=memIn=0.
